// File: rtl/prefix_adder4bit.sv
// prefix_adder4bit: 4-bit Kogge-Stone adder with carry-in and registered sum/carry-out

// black_cell: full prefix operator, combines group generate and propagate
module black_cell (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);
  assign g = gh | (ph & gl);
  assign p = ph & pl;
endmodule

// gray_cell: generate-only prefix operator for spans that reach the carry-in
module gray_cell (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  output logic g
);
  assign g = gh | (ph & gl);
endmodule

module prefix_adder4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       carry
);
  // Index k of each level vector holds bit position k-1, so index 0 is the carry-in
  logic [4:0] gv [4];
  logic [4:0] pv [4];
  logic [3:0] p;
  logic [4:0] res;
  assign p = a ^ b;
  assign gv[0] = {a & b, cin};
  assign pv[0] = {p, 1'b0};
  genvar l, k;
  generate
    for (l = 0; l < 3; l++) begin : g_lvl
      for (k = 0; k < 5; k++) begin : g_node
        if (k < (1 << l)) begin : g_pass
          assign gv[l+1][k] = gv[l][k];
          assign pv[l+1][k] = pv[l][k];
        end else if (k - (1 << l) < (1 << l)) begin : g_gray
          // Partner span already reaches the carry-in, so only G is needed
          gray_cell u_gray (
            .gh(gv[l][k]),
            .ph(pv[l][k]),
            .gl(gv[l][k-(1<<l)]),
            .g (gv[l+1][k])
          );
          assign pv[l+1][k] = 1'b0;
        end else begin : g_black
          black_cell u_black (
            .gh(gv[l][k]),
            .ph(pv[l][k]),
            .gl(gv[l][k-(1<<l)]),
            .pl(pv[l][k-(1<<l)]),
            .g (gv[l+1][k]),
            .p (pv[l+1][k])
          );
        end
      end
    end
  endgenerate
  assign res = {gv[3][4], p ^ gv[3][3:0]};
  // Output register stage; reset clears results immediately
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {carry, sum} <= 5'h00;
    else {carry, sum} <= res;
endmodule

// File: tb/tb_prefix_adder4bit.sv
// tb_prefix_adder4bit: vector table, exhaustive, random and reset/latency checks for prefix_adder4bit
module tb_prefix_adder4bit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a = 4'hA, b = 4'hC;
  logic       cin = 1'b0;
  logic [3:0] sum;
  logic       carry;
  int tests = 0, fails = 0;

  typedef struct {
    logic [3:0] a, b;
    logic       cin;
    logic [4:0] exp;
  } vec_t;

  prefix_adder4bit dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sum(sum), .carry(carry));

  always #5 clk = ~clk;

  function automatic logic [4:0] model(input logic [3:0] x, input logic [3:0] y, input logic c);
    int s;
    s = int'(x) + int'(y) + int'(c);
    return s[4:0];
  endfunction

  task automatic check(input string name, input logic [4:0] exp);
    tests++;
    if ({carry, sum} !== exp) begin
      fails++;
      $display("FAIL %s: got carry=%b sum=%h, expected carry=%b sum=%h", name, carry, sum, exp[4], exp[3:0]);
    end
  endtask

  task automatic drive(input logic [3:0] x, input logic [3:0] y, input logic c);
    a = x; b = y; cin = c;
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{4'b1010, 4'b1100, 1'b0, 5'b10110};
    vecs[1] = '{4'b0011, 4'b1100, 1'b1, 5'b10000};
    vecs[2] = '{4'b0000, 4'b1111, 1'b1, 5'b10000};
    vecs[3] = '{4'b0000, 4'b0000, 1'b0, 5'b00000};
    vecs[4] = '{4'hF,    4'h0,    1'b1, 5'b10000};
    vecs[5] = '{4'hF,    4'hF,    1'b1, 5'b11111};
    #1 check("reset_at_start", 5'h00);
    repeat (3) @(negedge clk);
    check("reset_hold_with_clk", 5'h00);
    rst_n = 1'b1;
    // Table vectors, back-to-back, one result per cycle
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
    // Mid-cycle input changes must not reach the outputs before the next edge
    drive(4'h7, 4'h8, 1'b1);
    @(negedge clk);
    check("latency_first", 5'h10);
    #2 drive(4'h1, 4'h2, 1'b0);
    #1 check("latency_hold", 5'h10);
    @(negedge clk);
    check("latency_second", 5'h03);
    // Async reset mid-operation discards the pending result
    drive(4'h9, 4'h9, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("async_clear", 5'h00);
    @(negedge clk);
    check("reset_discard", 5'h00);
    rst_n = 1'b1;
    drive(4'h5, 4'h6, 1'b1);
    #1 check("release_before_edge", 5'h00);
    @(negedge clk);
    check("first_after_release", 5'h0C);
    // Exhaustive sweep
    for (int c = 0; c < 2; c++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          drive(4'(x), 4'(y), 1'(c));
          @(negedge clk);
          check($sformatf("exh a=%h b=%h cin=%0d", x, y, c), model(4'(x), 4'(y), 1'(c)));
        end
    // Random vectors
    for (int i = 0; i < 200; i++) begin
      logic [3:0] x, y;
      logic c;
      x = 4'($urandom);
      y = 4'($urandom);
      c = 1'($urandom);
      drive(x, y, c);
      @(negedge clk);
      check($sformatf("rnd a=%h b=%h cin=%0d", x, y, c), model(x, y, c));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
